sram_axi_bridge: RTL and testbench

- Multi-channel bridge from the core's SRAM-like request/response ports to a single AXI3 master interface.
- Successor to the fixed inst/data SRAM wiring: the channel count is parametrised, reads and writes run concurrently, and arbitration is round-robin.
- Enforces read-after-write ordering on matching addresses.
- Sits between the CPU core (or its caches) and the SoC AXI interconnect.

---
 rtl/cpu_defs.sv | 21 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/sram_axi_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the CPU-side bus logic: SRAM-like size codes,
// AXI constants and the state encodings of the SRAM-to-AXI bridge FSMs.
package cpu_defs;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

  // The SRAM size code maps directly onto the low bits of AXI AxSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap and moves
// the pointer just past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Advance the pointer to winner+1 (mod N) when the grant is taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Multi-channel SRAM-like to AXI3 bridge with independent read and write
// engines, round-robin grant per engine and read-after-write protection.
module sram_axi_bridge
  import cpu_defs::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [4*NUM_CH-1:0]      ch_wstrb,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [2:0]               arsize,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ID_W-1:0]          awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [2:0]               awsize,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  rd_state_t rd_state, rd_state_next;
  wr_state_t wr_state, wr_state_next;

  logic [NUM_CH-1:0] busy, raw_block, rd_req, wr_req, rd_grant, wr_grant;
  logic [NUM_CH-1:0] rd_ok_vec, wr_ok_vec;
  logic [CH_W-1:0]   rd_idx, wr_idx;
  logic              rd_fire, wr_fire, aw_done, w_done;

  // Responses carry no error path and every transfer is a single beat.
  logic unused_ok;
  assign unused_ok = ^{rresp, bresp, rlast};

  // A read may not overtake a pending write to the same word.
  always_comb begin
    raw_block = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw_block[i] = (wr_state != W_IDLE) &&
                     (ch_addr[i*ADDR_W+2 +: ADDR_W-2] == awaddr[ADDR_W-1:2]);
    end
  end

  assign rd_req  = ch_req & ~ch_wr & ~busy & ~raw_block;
  assign wr_req  = ch_req &  ch_wr & ~busy;
  assign rd_fire = (rd_state == R_IDLE) && (rd_req != '0);
  assign wr_fire = (wr_state == W_IDLE) && (wr_req != '0);

  rr_arbiter #(.N(NUM_CH)) u_rd_arb (
    .clk(clk), .resetn(resetn), .req(rd_req), .advance(rd_fire),
    .grant(rd_grant), .grant_idx(rd_idx)
  );

  rr_arbiter #(.N(NUM_CH)) u_wr_arb (
    .clk(clk), .resetn(resetn), .req(wr_req), .advance(wr_fire),
    .grant(wr_grant), .grant_idx(wr_idx)
  );

  assign ch_addr_ok = (rd_fire ? rd_grant : '0) | (wr_fire ? wr_grant : '0);

  // Decode which channel each returning response belongs to.
  always_comb begin
    rd_ok_vec = '0;
    wr_ok_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ok_vec[i] = rvalid && rready && (rid == ID_W'(i));
      wr_ok_vec[i] = bvalid && bready && (bid == ID_W'(i));
    end
  end

  // State registers for both engines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_state_next;
      wr_state <= wr_state_next;
    end
  end

  // Read engine: issue AR, then wait for the single R beat.
  always_comb begin
    rd_state_next = rd_state;
    arvalid       = 1'b0;
    rready        = 1'b0;
    case (rd_state)
      R_IDLE: if (rd_fire) rd_state_next = R_ADDR;
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) rd_state_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Write engine: AW and W go out together and retire independently.
  always_comb begin
    wr_state_next = wr_state;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    case (wr_state)
      W_IDLE: if (wr_fire) wr_state_next = W_REQ;
      W_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) wr_state_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  assign wlast = wvalid;

  // Capture the granted read request and the returned read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr   <= '0;
      arsize   <= '0;
      arid     <= '0;
      ch_rdata <= '0;
    end else begin
      if (rd_fire) begin
        araddr <= ch_addr[rd_idx*ADDR_W +: ADDR_W];
        arsize <= axi_size(ch_size[rd_idx*2 +: 2]);
        arid   <= ID_W'(rd_idx);
      end
      if (rvalid && rready) ch_rdata <= rdata;
    end
  end

  // Capture the granted write request and track the AW/W handshakes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awaddr  <= '0;
      awsize  <= '0;
      awid    <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_fire) begin
      awaddr  <= ch_addr[wr_idx*ADDR_W +: ADDR_W];
      awsize  <= axi_size(ch_size[wr_idx*2 +: 2]);
      awid    <= ID_W'(wr_idx);
      wdata   <= ch_wdata[wr_idx*DATA_W +: DATA_W];
      wstrb   <= ch_wstrb[wr_idx*4 +: 4];
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_state == W_REQ) begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // Response pulses and per-channel outstanding flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch_data_ok <= '0;
      busy       <= '0;
    end else begin
      ch_data_ok <= rd_ok_vec | wr_ok_vec;
      busy       <= (busy & ~ch_data_ok) | ch_addr_ok;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge acting as both SRAM-side core and AXI slave.
module tb_sram_axi_bridge;
  import cpu_defs::*;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_CH-1:0]        ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*NUM_CH-1:0]      ch_size;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [4*NUM_CH-1:0]      ch_wstrb;
  logic [DATA_W*NUM_CH-1:0] ch_wdata;
  logic [DATA_W-1:0]        ch_rdata, rdata, wdata;
  logic [ID_W-1:0]          arid, rid, awid, bid;
  logic [ADDR_W-1:0]        araddr, awaddr;
  logic [2:0]               arsize, awsize;
  logic [1:0]               rresp, bresp;
  logic [3:0]               wstrb;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;

  int tests_run    = 0;
  int tests_failed = 0;

  sram_axi_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
    .ch_wstrb(ch_wstrb), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic [3:0] strb,
                               input logic [31:0] data);
    ch_req[ch]                   = 1'b1;
    ch_wr[ch]                    = wr;
    ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_size[ch*2 +: 2]           = size;
    ch_wstrb[ch*4 +: 4]          = strb;
    ch_wdata[ch*DATA_W +: DATA_W] = data;
  endtask

  task automatic waitAddrOk(input string tag, input logic [NUM_CH-1:0] expected);
    int n;
    n = 0;
    settle();
    while (ch_addr_ok == '0 && n < 20) begin
      tick();
      settle();
      n++;
    end
    checkOutput(tag, 64'(ch_addr_ok), 64'(expected));
  endtask

  initial begin
    logic [NUM_CH-1:0] exp_mask;
    int                exp_ch;

    resetn = 1'b0;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wstrb = '0; ch_wdata = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    bid = '0; bresp = 2'b00; bvalid = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_awvalid", 64'(awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(wvalid), 64'd0);
    checkOutput("rst_rready", 64'(rready), 64'd0);
    checkOutput("rst_bready", 64'(bready), 64'd0);
    checkOutput("rst_data_ok", 64'(ch_data_ok), 64'd0);
    checkOutput("rst_rdata", 64'(ch_rdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Single read on channel 1.
    applyStimulus(1, 1'b0, 32'h1fc0_0010, SIZE_WORD, 4'h0, 32'h0);
    settle();
    checkOutput("rd1_addr_ok", 64'(ch_addr_ok), 64'b10);
    tick(); ch_req = '0; settle();
    checkOutput("rd1_arvalid", 64'(arvalid), 64'd1);
    checkOutput("rd1_araddr", 64'(araddr), 64'h1fc0_0010);
    checkOutput("rd1_arid", 64'(arid), 64'd1);
    checkOutput("rd1_arsize", 64'(arsize), 64'd2);
    tick(); rvalid = 1'b1; rid = 4'd1; rdata = 32'hdead_beef; settle();
    checkOutput("rd1_rready", 64'(rready), 64'd1);
    tick(); rvalid = 1'b0; settle();
    checkOutput("rd1_data_ok", 64'(ch_data_ok), 64'b10);
    checkOutput("rd1_rdata", 64'(ch_rdata), 64'hdead_beef);
    tick(); settle();
    checkOutput("rd1_data_ok_pulse", 64'(ch_data_ok), 64'd0);

    // Round-robin between two continuously requesting read channels.
    applyStimulus(0, 1'b0, 32'h1000_0000, SIZE_WORD, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 32'h1000_0100, SIZE_WORD, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_ch   = k % 2;
      exp_mask = NUM_CH'(1) << exp_ch;
      waitAddrOk($sformatf("rr_grant%0d", k), exp_mask);
      tick(); settle();
      checkOutput($sformatf("rr_arid%0d", k), 64'(arid), 64'(exp_ch));
      checkOutput($sformatf("rr_araddr%0d", k), 64'(araddr), 64'(32'h1000_0000 + 32'(exp_ch * 256)));
      tick(); rvalid = 1'b1; rid = ID_W'(exp_ch); rdata = 32'h0000_1000 + 32'(k);
      tick(); rvalid = 1'b0;
      if (k == 3) ch_req = '0;
      settle();
      checkOutput($sformatf("rr_data_ok%0d", k), 64'(ch_data_ok), 64'(exp_mask));
      checkOutput($sformatf("rr_rdata%0d", k), 64'(ch_rdata), 64'(32'h0000_1000 + 32'(k)));
    end

    // Concurrent read on ch0 and write on ch1.
    tick();
    applyStimulus(0, 1'b0, 32'h8000_1000, SIZE_WORD, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 32'h8000_0000, SIZE_WORD, 4'hf, 32'h1234_5678);
    settle();
    checkOutput("cc_addr_ok", 64'(ch_addr_ok), 64'b11);
    tick(); ch_req = '0; settle();
    checkOutput("cc_arvalid", 64'(arvalid), 64'd1);
    checkOutput("cc_arid", 64'(arid), 64'd0);
    checkOutput("cc_awvalid", 64'(awvalid), 64'd1);
    checkOutput("cc_wvalid", 64'(wvalid), 64'd1);
    checkOutput("cc_wlast", 64'(wlast), 64'd1);
    checkOutput("cc_awaddr", 64'(awaddr), 64'h8000_0000);
    checkOutput("cc_awid", 64'(awid), 64'd1);
    checkOutput("cc_wdata", 64'(wdata), 64'h1234_5678);
    checkOutput("cc_wstrb", 64'(wstrb), 64'hf);
    tick(); bvalid = 1'b1; bid = 4'd1; settle();
    checkOutput("cc_rready", 64'(rready), 64'd1);
    checkOutput("cc_bready", 64'(bready), 64'd1);
    checkOutput("cc_awvalid_drop", 64'(awvalid), 64'd0);
    tick(); bvalid = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'hcafe_f00d; settle();
    checkOutput("cc_wr_data_ok", 64'(ch_data_ok), 64'b10);
    tick(); rvalid = 1'b0; settle();
    checkOutput("cc_rd_data_ok", 64'(ch_data_ok), 64'b01);
    checkOutput("cc_rdata", 64'(ch_rdata), 64'hcafe_f00d);

    // AW handshake delayed while W completes immediately.
    tick(); awready = 1'b0;
    applyStimulus(1, 1'b1, 32'h8000_0020, SIZE_HALF, 4'h3, 32'h0000_abcd);
    settle();
    checkOutput("sk_addr_ok", 64'(ch_addr_ok), 64'b10);
    tick(); ch_req = '0; settle();
    checkOutput("sk_awvalid1", 64'(awvalid), 64'd1);
    checkOutput("sk_wvalid1", 64'(wvalid), 64'd1);
    checkOutput("sk_awsize", 64'(awsize), 64'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) awready = 1'b1;
      settle();
      checkOutput($sformatf("sk_wvalid%0d", c), 64'(wvalid), 64'd0);
      checkOutput($sformatf("sk_awvalid%0d", c), 64'(awvalid), 64'd1);
      checkOutput($sformatf("sk_awaddr%0d", c), 64'(awaddr), 64'h8000_0020);
    end
    tick(); settle();
    checkOutput("sk_awvalid_drop", 64'(awvalid), 64'd0);
    checkOutput("sk_bready", 64'(bready), 64'd1);
    checkOutput("sk_no_ok_early", 64'(ch_data_ok), 64'd0);
    bvalid = 1'b1; bid = 4'd1;
    tick(); bvalid = 1'b0; settle();
    checkOutput("sk_data_ok", 64'(ch_data_ok), 64'b10);

    // Read-after-write hazard on the same word.
    tick();
    applyStimulus(1, 1'b1, 32'h8000_0004, SIZE_WORD, 4'hf, 32'h5555_aaaa);
    settle();
    checkOutput("raw_wr_addr_ok", 64'(ch_addr_ok), 64'b10);
    tick(); ch_req = '0;
    applyStimulus(0, 1'b0, 32'h8000_0006, SIZE_HALF, 4'h0, 32'h0);
    settle();
    checkOutput("raw_blk_addr_ok", 64'(ch_addr_ok), 64'd0);
    checkOutput("raw_blk_arvalid", 64'(arvalid), 64'd0);
    for (int c = 0; c < 6; c++) begin
      tick(); settle();
      checkOutput($sformatf("raw_wait_addr_ok%0d", c), 64'(ch_addr_ok), 64'd0);
      checkOutput($sformatf("raw_wait_arvalid%0d", c), 64'(arvalid), 64'd0);
    end
    tick(); bvalid = 1'b1; bid = 4'd1; settle();
    checkOutput("raw_bhs_addr_ok", 64'(ch_addr_ok), 64'd0);
    tick(); bvalid = 1'b0; settle();
    checkOutput("raw_rel_addr_ok", 64'(ch_addr_ok), 64'b01);
    checkOutput("raw_wr_data_ok", 64'(ch_data_ok), 64'b10);
    tick(); ch_req = '0; settle();
    checkOutput("raw_arvalid", 64'(arvalid), 64'd1);
    checkOutput("raw_araddr", 64'(araddr), 64'h8000_0006);
    checkOutput("raw_arsize", 64'(arsize), 64'd1);
    tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_aaaa;
    tick(); rvalid = 1'b0; settle();
    checkOutput("raw_rd_data_ok", 64'(ch_data_ok), 64'b01);
    checkOutput("raw_rdata", 64'(ch_rdata), 64'h5555_aaaa);

    // Reset while a read sits in the data phase.
    tick();
    applyStimulus(0, 1'b0, 32'h0000_0040, SIZE_WORD, 4'h0, 32'h0);
    settle();
    checkOutput("mr_addr_ok", 64'(ch_addr_ok), 64'b01);
    tick(); ch_req = '0;
    tick(); settle();
    checkOutput("mr_rready_pre", 64'(rready), 64'd1);
    resetn = 1'b0;
    settle();
    checkOutput("mr_rready", 64'(rready), 64'd0);
    checkOutput("mr_arvalid", 64'(arvalid), 64'd0);
    checkOutput("mr_data_ok", 64'(ch_data_ok), 64'd0);
    checkOutput("mr_rdata", 64'(ch_rdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    applyStimulus(0, 1'b0, 32'h0000_0100, SIZE_WORD, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 32'h0000_0200, SIZE_WORD, 4'h0, 32'h0);
    settle();
    checkOutput("mr2_addr_ok", 64'(ch_addr_ok), 64'b01);
    tick(); ch_req = '0; settle();
    checkOutput("mr2_arid", 64'(arid), 64'd0);
    checkOutput("mr2_araddr", 64'(araddr), 64'h0000_0100);
    tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0bad_cafe;
    tick(); rvalid = 1'b0; settle();
    checkOutput("mr2_data_ok", 64'(ch_data_ok), 64'b01);
    checkOutput("mr2_rdata", 64'(ch_rdata), 64'h0bad_cafe);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
